// File: rtl/avmm_pattern_pkg.sv
// Shared types and constants for the Avalon-MM pattern write/read-check master.
package avmm_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FIN
  } state_e;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/avmm_pattern_master.sv
// Avalon-MM master that writes an incrementing pattern (seed + i) to a word range,
// reads it back one transfer at a time, and records mismatches.
module avmm_pattern_master
  import avmm_pattern_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       seed,
  input  logic              check_only,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  err_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       seed_q, seed_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic [CNT_W-1:0]  idx_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] base_aligned;
  logic [31:0]       exp_word;
  logic              last;
  logic              cmp_fire;

  assign idx_nxt      = idx_q + 1'b1;
  assign addr_nxt     = base_q + (ADDR_W'(idx_nxt) << 2);
  assign base_aligned = {base_addr[ADDR_W-1:2], 2'b00};
  assign exp_word     = seed_q + 32'(idx_q);
  assign last         = (idx_q == cnt_q - 1'b1);
  // Zero-latency slaves may return data in the same cycle the read is accepted.
  assign cmp_fire     = avm_readdatavalid &&
                        ((state_q == ST_RD_WAIT) ||
                         (state_q == ST_RD_REQ && !avm_waitrequest));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    read_d      = read_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base_aligned;
          cnt_d       = word_count;
          seed_d      = seed;
          idx_d       = '0;
          error_d     = 1'b0;
          err_addr_d  = '0;
          err_count_d = '0;
          busy_d      = 1'b1;
          if (word_count == '0) begin
            state_d = ST_FIN;
          end else if (check_only) begin
            addr_d  = base_aligned;
            read_d  = 1'b1;
            state_d = ST_RD_REQ;
          end else begin
            addr_d  = base_aligned;
            wdata_d = seed;
            write_d = 1'b1;
            state_d = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (!avm_waitrequest) begin
          if (last) begin
            idx_d   = '0;
            addr_d  = base_q;
            write_d = 1'b0;
            read_d  = 1'b1;
            state_d = ST_RD_REQ;
          end else begin
            idx_d   = idx_nxt;
            addr_d  = addr_nxt;
            wdata_d = seed_q + 32'(idx_nxt);
          end
        end
      end
      ST_RD_REQ: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: ;
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmp_fire) begin
      if (avm_readdata != exp_word) begin
        error_d = 1'b1;
        if (!error_q) err_addr_d = addr_q;
        if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + 1'b1;
      end
      if (last) begin
        read_d  = 1'b0;
        state_d = ST_FIN;
      end else begin
        idx_d   = idx_nxt;
        addr_d  = addr_nxt;
        read_d  = 1'b1;
        state_d = ST_RD_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      seed_q      <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_byteenable = BYTEEN_ALL;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_addr       = err_addr_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_avmm_pattern_master.sv
// Bench for avmm_pattern_master: memory slave with stall/latency knobs and a run-level pattern model.
module tb_avmm_pattern_master;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic [31:0] seed;
  logic        check_only;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] err_addr;
  logic [15:0] err_count;

  avmm_pattern_master #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .seed              (seed),
    .check_only        (check_only),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .err_addr          (err_addr),
    .err_count         (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Slave memory and behaviour knobs
  logic [31:0] mem [logic [31:0]];
  int          stall_n   = 0;
  int          rd_lat    = 0;
  int          stall_cnt = 0;
  bit          pending   = 0;
  int          pcnt      = 0;
  logic [31:0] pdata     = '0;
  int          done_cnt  = 0;
  int          nreads    = 0;
  bit          held      = 0;
  logic [65:0] snap      = '0;

  // Expected transfers of the current run, in issue order
  logic [63:0] exp_wr [$];
  logic [31:0] exp_rd [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Slave responses are driven on the falling edge so they are stable at the rising edge.
  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    if (pending) begin
      if (pcnt == 1) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pdata;
      end else begin
        pcnt--;
      end
    end
    if ((avm_read || avm_write) && !reset) begin
      if (stall_cnt < stall_n) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        avm_waitrequest = 1'b0;
        stall_cnt       = 0;
        if (avm_read && rd_lat == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = mem_rd(avm_address);
        end
      end
    end else begin
      avm_waitrequest = 1'b0;
      stall_cnt       = 0;
    end
  end

  // Per-cycle compare process: bus rules, stall stability, and transfers against the run model.
  always @(posedge clk) begin
    logic [63:0] e;
    logic [31:0] ea;
    if (pending && avm_readdatavalid) pending = 0;
    if (reset) begin
      held = 0;
    end else begin
      chk("rd_wr_exclusive", {63'b0, avm_read && avm_write}, 64'h0);
      chk("byteenable", {60'b0, avm_byteenable}, 64'hF);
      if (!busy) chk("no_req_when_idle", {62'b0, avm_read, avm_write}, 64'h0);
      if (held) chk("stall_hold", {62'b0, snap}, {62'b0, avm_read, avm_write, avm_address, avm_writedata});
      held = (avm_read || avm_write) && avm_waitrequest;
      snap = {avm_read, avm_write, avm_address, avm_writedata};
      if (avm_write && !avm_waitrequest) begin
        e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 64'hx;
        chk("write_xfer", {avm_address, avm_writedata}, e);
        mem[avm_address] = avm_writedata;
      end
      if (avm_read && !avm_waitrequest) begin
        nreads++;
        ea = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hx;
        chk("read_addr", {32'h0, avm_address}, {32'h0, ea});
        if (rd_lat > 0) begin
          pending = 1;
          pcnt    = rd_lat;
          pdata   = mem_rd(avm_address);
        end
      end
      if (done) done_cnt++;
    end
  end

  // Run model: expected transfer sequence and expected error summary from the current memory image.
  task automatic build(input logic [31:0] base, input logic [15:0] cnt, input logic [31:0] sd,
                       input bit co, output int errs, output logic [31:0] first_ea);
    logic [31:0] a, d;
    exp_wr.delete();
    exp_rd.delete();
    errs     = 0;
    first_ea = 32'h0;
    for (int i = 0; i < int'(cnt); i++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      d = sd + 32'(i);
      if (!co) exp_wr.push_back({a, d});
      exp_rd.push_back(a);
      if (co && mem_rd(a) != d) begin
        if (errs == 0) first_ea = a;
        errs++;
      end
    end
  endtask

  task automatic run(input string name, input logic [31:0] base, input logic [15:0] cnt,
                     input logic [31:0] sd, input bit co, input int stall, input int lat,
                     input int mid, output int cyc);
    int          errs;
    logic [31:0] ea;
    stall_n  = stall;
    rd_lat   = lat;
    build(base, cnt, sd, co, errs, ea);
    done_cnt = 0;
    @(negedge clk);
    base_addr  = base;
    word_count = cnt;
    seed       = sd;
    check_only = co;
    start      = 1'b1;
    cyc        = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (mid > 0 && cyc == mid) begin
        start      = 1'b1;
        base_addr  = 32'h4000;
        word_count = 16'd9;
        seed       = 32'h1234;
        check_only = 1'b0;
      end
      if (mid > 0 && cyc == mid + 1) start = 1'b0;
    end while (!done && cyc < 3000);
    chk({name, "_done_seen"}, {63'b0, done}, 64'h1);
    chk({name, "_busy_at_done"}, {63'b0, busy}, 64'h0);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, {63'b0, done}, 64'h0);
    chk({name, "_done_count"}, 64'(done_cnt), 64'h1);
    chk({name, "_error"}, {63'b0, error}, {63'b0, errs != 0});
    chk({name, "_err_addr"}, {32'h0, err_addr}, {32'h0, ea});
    chk({name, "_err_count"}, {48'h0, err_count}, 64'(errs));
    chk({name, "_writes_left"}, 64'(exp_wr.size()), 64'h0);
    chk({name, "_reads_left"}, 64'(exp_rd.size()), 64'h0);
  endtask

  initial begin
    int cyc;
    int          errs;
    logic [31:0] ea;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    seed = '0;
    check_only = 1'b0;
    avm_readdata = '0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_done", {63'b0, done}, 64'h0);
    chk("rst_req", {62'b0, avm_read, avm_write}, 64'h0);
    chk("rst_addr", {32'h0, avm_address}, 64'h0);
    chk("rst_wdata", {32'h0, avm_writedata}, 64'h0);
    chk("rst_err", {15'h0, error, err_addr, err_count}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    run("basic", 32'h100, 16'd4, 32'hA5A5_0000, 1'b0, 0, 0, 0, cyc);
    chk("basic_mem_10c", {32'h0, mem_rd(32'h10C)}, 64'hA5A5_0003);
    chk("basic_mem_100", {32'h0, mem_rd(32'h100)}, 64'hA5A5_0000);

    run("stall3", 32'h101, 16'd4, 32'hA5A5_0000, 1'b0, 3, 0, 0, cyc);
    chk("stall3_mem_108", {32'h0, mem_rd(32'h108)}, 64'hA5A5_0002);

    mem[32'h108] = 32'h0;
    run("chk_only", 32'h100, 16'd4, 32'hA5A5_0000, 1'b1, 0, 0, 0, cyc);
    chk("chk_only_err_addr_lit", {32'h0, err_addr}, 64'h108);
    chk("chk_only_err_cnt_lit", {48'h0, err_count}, 64'h1);
    chk("chk_only_err_hold", {63'b0, error}, 64'h1);

    run("count0", 32'h300, 16'd0, 32'h5, 1'b0, 0, 0, 0, cyc);
    chk("count0_latency", 64'(cyc), 64'h2);

    mem[32'h100] = 32'hDEAD_BEEF;
    mem[32'h104] = 32'h0;
    run("multi_err_lat2", 32'h100, 16'd4, 32'hA5A5_0000, 1'b1, 1, 2, 0, cyc);
    chk("multi_err_addr_lit", {32'h0, err_addr}, 64'h100);
    chk("multi_err_cnt_lit", {48'h0, err_count}, 64'h3);

    run("wrap", 32'hFFFF_FFF8, 16'd3, 32'hFFFF_FFFE, 1'b0, 1, 0, 3, cyc);
    chk("wrap_mem_0", {31'h0, mem.exists(32'h0), mem_rd(32'h0)}, {31'h0, 1'b1, 32'h0});
    chk("wrap_mem_fffffffc", {32'h0, mem_rd(32'hFFFF_FFFC)}, 64'hFFFF_FFFF);
    chk("wrap_no_restart_mem", {63'b0, mem.exists(32'h4000)}, 64'h0);

    // Reset while a read is outstanding, with its data arriving after reset.
    stall_n = 0;
    rd_lat  = 3;
    build(32'h200, 16'd4, 32'h77, 1'b0, errs, ea);
    done_cnt = 0;
    nreads   = 0;
    @(negedge clk);
    base_addr  = 32'h200;
    word_count = 16'd4;
    seed       = 32'h77;
    check_only = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (nreads < 1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstmid_reached_rd_wait", {63'b0, nreads >= 1}, 64'h1);
    chk("rstmid_read_low", {63'b0, avm_read}, 64'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_req", {62'b0, avm_read, avm_write}, 64'h0);
    chk("rstmid_busy_done", {62'b0, busy, done}, 64'h0);
    chk("rstmid_addr_data", {avm_address, avm_writedata}, 64'h0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstmid_late_ignored_err", {15'h0, error, err_addr, err_count}, 64'h0);
    chk("rstmid_idle", {61'b0, busy, avm_read, avm_write}, 64'h0);
    chk("rstmid_no_done", 64'(done_cnt), 64'h0);
    exp_wr.delete();
    exp_rd.delete();

    run("after_rst", 32'h200, 16'd2, 32'h77, 1'b0, 0, 1, 0, cyc);
    chk("after_rst_mem_204", {32'h0, mem_rd(32'h204)}, 64'h78);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
